// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the five-stage MIPS pipeline.
// Owns the PC, selects the next fetch address from the sequential, branch, J/JAL
// and JR/JALR paths, and registers the fetched word into IF/ID for decode.
`timescale 1ns/1ps

module fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter int unsigned IM_AW      = 10,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [15:0]      br_imm,
    input  logic             j_en,
    input  logic [25:0]      j_index,
    input  logic             jr_en,
    input  logic [31:0]      jr_target,
    input  logic [31:0]      im_instr,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc8,
    output logic             if_id_valid,
    output logic             pc_err
);

    // First byte address past the instruction memory, kept 33 bits wide so a
    // window ending exactly at 2^32 does not wrap to zero.
    localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + (33'd4 << IM_AW);

    localparam logic [31:0] NOP = 32'h0000_0000;

    // State
    logic [31:0] pc_q,          pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q,    if_id_pc_d;
    logic [31:0] if_id_pc8_q,   if_id_pc8_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        pc_err_q,      pc_err_d;

    // Candidate targets and selection
    logic [31:0] seq_pc;
    logic [31:0] delay_pc;
    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] next_pc;
    logic        redirect;
    logic        range_err;

    // IM word index relative to the base of instruction memory.
    assign im_addr = IM_AW'((pc_q - PC_RESET) >> 2);

    // Candidate next-PC values; branch and jump resolve against the delay-slot PC.
    always_comb begin
        seq_pc    = pc_q + 32'd4;
        delay_pc  = if_id_pc_q + 32'd4;
        br_off    = {{14{br_imm[15]}}, br_imm, 2'b00};
        br_target = delay_pc + br_off;
        j_target  = {delay_pc[31:28], j_index, 2'b00};
    end

    // Fixed-priority redirect select: JR over J over branch over sequential.
    always_comb begin
        redirect = jr_en | j_en | br_taken;
        if (jr_en) begin
            next_pc = jr_target;
        end else if (j_en) begin
            next_pc = j_target;
        end else if (br_taken) begin
            next_pc = br_target;
        end else begin
            next_pc = seq_pc;
        end
    end

    // Selected next PC must be word aligned and inside the IM window.
    always_comb begin
        range_err = 1'b0;
        if (next_pc < PC_RESET) begin
            range_err = 1'b1;
        end
        if ({1'b0, next_pc} >= PC_LIMIT) begin
            range_err = 1'b1;
        end
        if (next_pc[1:0] != 2'b00) begin
            range_err = 1'b1;
        end
    end

    // Next-state for PC and IF/ID; stall holds everything, an error freezes the PC.
    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc8_d   = if_id_pc8_q;
        if_id_valid_d = if_id_valid_q;
        pc_err_d      = pc_err_q;

        if (!stall) begin
            if (pc_err_q || range_err) begin
                // Out-of-window fetch: keep the PC and feed bubbles until reset.
                pc_err_d      = 1'b1;
                if_id_instr_d = NOP;
                if_id_valid_d = 1'b0;
            end else begin
                pc_d        = next_pc;
                if_id_pc_d  = pc_q;
                if_id_pc8_d = pc_q + 32'd8;
                if (redirect && !DELAY_SLOT) begin
                    // No delay slot: the word fetched behind a redirect is squashed.
                    if_id_instr_d = NOP;
                    if_id_valid_d = 1'b0;
                end else begin
                    if_id_instr_d = im_instr;
                    if_id_valid_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= PC_RESET;
            if_id_instr_q <= NOP;
            if_id_pc_q    <= PC_RESET;
            if_id_pc8_q   <= PC_RESET + 32'd8;
            if_id_valid_q <= 1'b0;
            pc_err_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc8_q   <= if_id_pc8_d;
            if_id_valid_q <= if_id_valid_d;
            pc_err_q      <= pc_err_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc8   = if_id_pc8_q;
    assign if_id_valid = if_id_valid_q;
    assign pc_err      = pc_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one instance with a branch delay slot and one
// without, sharing all redirect inputs, each fed by its own combinational IM model.
`timescale 1ns/1ps

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        j_en;
    logic [25:0] j_index;
    logic        jr_en;
    logic [31:0] jr_target;

    logic [31:0] im_instr0, im_instr1;
    logic [9:0]  im_addr0, im_addr1;
    logic [31:0] pc0, pc1;
    logic [31:0] instr0, instr1;
    logic [31:0] ifpc0, ifpc1;
    logic [31:0] ifpc80, ifpc81;
    logic        valid0, valid1;
    logic        err0, err1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // IM contents: each word is tagged with its own index.
    function automatic logic [31:0] im(input logic [9:0] a);
        return 32'hC0DE_0000 | {22'b0, a};
    endfunction

    assign im_instr0 = im(im_addr0);
    assign im_instr1 = im(im_addr1);

    fetch_stage #(
        .PC_RESET   (32'h0000_3000),
        .IM_AW      (10),
        .DELAY_SLOT (1'b1)
    ) u_ds (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_imm      (br_imm),
        .j_en        (j_en),
        .j_index     (j_index),
        .jr_en       (jr_en),
        .jr_target   (jr_target),
        .im_instr    (im_instr0),
        .im_addr     (im_addr0),
        .pc          (pc0),
        .if_id_instr (instr0),
        .if_id_pc    (ifpc0),
        .if_id_pc8   (ifpc80),
        .if_id_valid (valid0),
        .pc_err      (err0)
    );

    fetch_stage #(
        .PC_RESET   (32'h0000_3000),
        .IM_AW      (10),
        .DELAY_SLOT (1'b0)
    ) u_nods (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_imm      (br_imm),
        .j_en        (j_en),
        .j_index     (j_index),
        .jr_en       (jr_en),
        .jr_target   (jr_target),
        .im_instr    (im_instr1),
        .im_addr     (im_addr1),
        .pc          (pc1),
        .if_id_instr (instr1),
        .if_id_pc    (ifpc1),
        .if_id_pc8   (ifpc81),
        .if_id_valid (valid1),
        .pc_err      (err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle reset pulse, released 1 ns after the following edge.
    task automatic reset_pulse();
        #2 reset = 1'b0;
        #1;
        chk("rst_pc", pc0, 32'h3000);
        chk("rst_err", {31'b0, err0}, 32'd0);
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_imm    = 16'h0;
        j_en      = 1'b0;
        j_index   = 26'h0;
        jr_en     = 1'b0;
        jr_target = 32'h0;

        // Reset state
        tick();
        tick();
        chk("reset_pc", pc0, 32'h3000);
        chk("reset_instr", instr0, 32'h0);
        chk("reset_ifpc", ifpc0, 32'h3000);
        chk("reset_ifpc8", ifpc80, 32'h3008);
        chk("reset_valid", {31'b0, valid0}, 32'd0);
        chk("reset_err", {31'b0, err0}, 32'd0);
        chk("reset_imaddr", {22'b0, im_addr0}, 32'd0);
        reset = 1'b1;
        chk("release_pc", pc0, 32'h3000);

        // Sequential fetch
        tick();
        chk("seq1_pc", pc0, 32'h3004);
        chk("seq1_imaddr", {22'b0, im_addr0}, 32'd1);
        chk("seq1_ifpc", ifpc0, 32'h3000);
        chk("seq1_instr", instr0, 32'hC0DE_0000);
        chk("seq1_valid", {31'b0, valid0}, 32'd1);
        tick();
        chk("seq2_pc", pc0, 32'h3008);
        chk("seq2_ifpc", ifpc0, 32'h3004);
        tick();
        chk("seq3_pc", pc0, 32'h300C);
        chk("seq3_ifpc", ifpc0, 32'h3008);
        tick();
        chk("seq4_pc", pc0, 32'h3010);
        chk("seq4_imaddr", {22'b0, im_addr0}, 32'd4);
        tick();
        chk("seq5_ifpc", ifpc0, 32'h3010);

        // Backward branch from if_id_pc 0x3010
        br_taken = 1'b1;
        br_imm   = 16'hFFFC;
        tick();
        chk("brb_pc", pc0, 32'h3004);
        chk("brb_ifpc", ifpc0, 32'h3014);
        chk("brb_ds_instr", instr0, 32'hC0DE_0005);
        chk("brb_ds_valid", {31'b0, valid0}, 32'd1);
        chk("brb_nods_instr", instr1, 32'h0);
        chk("brb_nods_valid", {31'b0, valid1}, 32'd0);
        chk("brb_nods_pc", pc1, 32'h3004);

        // JR back to 0x3010 so the forward branch resolves from there
        br_taken  = 1'b0;
        jr_en     = 1'b1;
        jr_target = 32'h3010;
        tick();
        chk("jr1_pc", pc0, 32'h3010);
        chk("jr1_nods_valid", {31'b0, valid1}, 32'd0);
        jr_en = 1'b0;
        tick();
        chk("jr1b_ifpc", ifpc0, 32'h3010);
        chk("jr1b_nods_valid", {31'b0, valid1}, 32'd1);
        chk("jr1b_nods_instr", instr1, 32'hC0DE_0004);

        // Forward branch
        br_taken = 1'b1;
        br_imm   = 16'h0003;
        tick();
        chk("brf_pc", pc0, 32'h3020);
        chk("brf_ds_instr", instr0, 32'hC0DE_0005);

        // Line up if_id_pc = 0x3008 for the jump
        br_taken  = 1'b0;
        jr_en     = 1'b1;
        jr_target = 32'h3004;
        tick();
        jr_en = 1'b0;
        tick();
        tick();
        chk("jal_pre_ifpc", ifpc0, 32'h3008);
        chk("jal_link", ifpc80, 32'h3010);
        j_en    = 1'b1;
        j_index = 26'h0000C40;
        tick();
        chk("jal_pc", pc0, 32'h3100);

        // JR wins over J
        jr_en     = 1'b1;
        jr_target = 32'h3040;
        tick();
        chk("jr_prio_pc", pc0, 32'h3040);
        chk("jr_prio_instr", instr0, 32'hC0DE_0040);
        j_en  = 1'b0;
        jr_en = 1'b0;

        // Stall with a pending branch
        stall    = 1'b1;
        br_taken = 1'b1;
        br_imm   = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc0, 32'h3040);
            chk("stall_ifpc", ifpc0, 32'h3100);
            chk("stall_instr", instr0, 32'hC0DE_0040);
        end
        stall = 1'b0;
        tick();
        chk("unstall_pc", pc0, 32'h3114);
        chk("unstall_ifpc", ifpc0, 32'h3040);
        chk("unstall_instr", instr0, 32'hC0DE_0010);
        br_taken = 1'b0;

        // Below-window JR
        jr_en     = 1'b1;
        jr_target = 32'h2FFC;
        tick();
        chk("low_err", {31'b0, err0}, 32'd1);
        chk("low_pc", pc0, 32'h3114);
        chk("low_valid", {31'b0, valid0}, 32'd0);
        chk("low_instr", instr0, 32'h0);
        jr_en = 1'b0;
        tick();
        chk("low_hold_pc", pc0, 32'h3114);
        chk("low_hold_err", {31'b0, err0}, 32'd1);
        reset_pulse();

        // Misaligned JR
        jr_en     = 1'b1;
        jr_target = 32'h3002;
        tick();
        chk("mis_err", {31'b0, err0}, 32'd1);
        chk("mis_pc", pc0, 32'h3000);
        jr_en = 1'b0;
        reset_pulse();

        // Last IM word is legal; falling off the end is not
        jr_en     = 1'b1;
        jr_target = 32'h3FFC;
        tick();
        chk("last_pc", pc0, 32'h3FFC);
        chk("last_err", {31'b0, err0}, 32'd0);
        chk("last_imaddr", {22'b0, im_addr0}, 32'h3FF);
        jr_en = 1'b0;
        tick();
        chk("end_err", {31'b0, err0}, 32'd1);
        chk("end_pc", pc0, 32'h3FFC);
        jr_en     = 1'b1;
        jr_target = 32'h3000;
        tick();
        chk("sticky_err", {31'b0, err0}, 32'd1);
        chk("sticky_pc", pc0, 32'h3FFC);
        chk("sticky_valid", {31'b0, valid0}, 32'd0);
        jr_en = 1'b0;
        reset_pulse();

        // Async reset during a stalled JR
        tick();
        chk("ar_pre_pc", pc0, 32'h3004);
        stall     = 1'b1;
        jr_en     = 1'b1;
        jr_target = 32'h3080;
        tick();
        chk("ar_stall_pc", pc0, 32'h3004);
        #2 reset = 1'b0;
        #1;
        chk("ar_pc", pc0, 32'h3000);
        chk("ar_ifpc", ifpc0, 32'h3000);
        chk("ar_ifpc8", ifpc80, 32'h3008);
        chk("ar_valid", {31'b0, valid0}, 32'd0);
        chk("ar_instr", instr0, 32'h0);
        stall = 1'b0;
        jr_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("ar_post_pc", pc0, 32'h3004);
        chk("ar_post_ifpc", ifpc0, 32'h3000);
        chk("ar_post_valid", {31'b0, valid0}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline.
- Owns the program counter and selects the next PC from: sequential, conditional branch, J/JAL and JR.
- Drives the word address into the instruction memory and captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Redirect requests come from ID and are resolved against the PC held in IF/ID.

Parameters:
- PC_RESET, 32'h00003000, PC value after reset and base of instruction memory.
- IM_AW, 10, instruction-memory word-address width; depth = 2^IM_AW words.
- DELAY_SLOT, 1, 1 = MIPS branch delay slot (no flush on redirect); 0 = instruction fetched behind a redirect is squashed.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall from ID; holds PC and IF/ID.
- br_taken  in  1  ID branch resolved taken.
- br_imm  in  16  raw branch immediate from the ID instruction.
- j_en  in  1  ID holds J or JAL.
- j_index  in  26  jump instr_index field.
- jr_en  in  1  ID holds JR/JALR.
- jr_target  in  32  forwarded register target.
- im_instr  in  32  instruction word from IM, combinational read of im_addr.
- im_addr  out  IM_AW  IM word index = (pc - PC_RESET) >> 2.
- pc  out  32  current fetch PC.
- if_id_instr  out  32  registered instruction to ID.
- if_id_pc  out  32  registered PC of that instruction.
- if_id_pc8  out  32  if_id_pc + 8, link value for JAL/JALR.
- if_id_valid  out  1  IF/ID holds a real instruction.
- pc_err  out  1  sticky: fetch left the IM window.

Behaviour:
- reset low, async: pc = PC_RESET, if_id_instr = 0, if_id_pc = PC_RESET, if_id_pc8 = PC_RESET + 8, if_id_valid = 0, pc_err = 0. Deassertion is taken at the next clk edge.
- im_addr is combinational from pc, truncated to IM_AW bits. im_instr is sampled the same cycle (1-cycle fetch latency to IF/ID).
- Next-PC priority, evaluated only when stall = 0:
  - jr_en: jr_target.
  - j_en: {if_id_pc[31:28] of (if_id_pc + 4), j_index, 2'b00}.
  - br_taken: if_id_pc + 4 + (sign-extended br_imm << 2).
  - otherwise: pc + 4.
- All additions are 32-bit modulo 2^32; wrap is silent and is caught by the range check.
- Simultaneous redirects resolve by the priority above; the lower-priority request is dropped.
- stall = 1:
  - pc and all IF/ID registers hold.
  - Redirect inputs are ignored that cycle; ID re-presents them once the stall releases.
- stall = 0, no redirect, or DELAY_SLOT = 1: IF/ID loads {im_instr, pc, pc + 8}, valid = 1.
- DELAY_SLOT = 0 with any redirect accepted: IF/ID loads instr = 0 (NOP) and valid = 0; pc still loads the target.
- Range check on the selected next PC:
  - Error if next < PC_RESET, or next >= PC_RESET + 4·2^IM_AW, or next[1:0] != 0.
  - On error: pc_err sets and stays 1 until reset; pc holds its current value.
  - While pc_err = 1: the PC is frozen and IF/ID loads NOP with valid = 0 each non-stalled cycle.
- A redirect into the last IM word is legal; the following sequential pc + 4 raises pc_err.
- Reset asserted mid-stall or mid-redirect: the reset values win immediately, and no pending redirect survives.

Test Plan:
- Reset sequence: reset low 2 cycles then high; 4 free-run cycles with no stall -> pc steps 0x3000, 0x3004, 0x3008, 0x300C; im_addr 0..3; if_id_pc trails pc by one cycle; if_id_valid rises on the first edge after release.
- Branch: if_id_pc = 0x3010, br_taken = 1, br_imm = 16'hFFFC -> next pc = 0x3004. Repeat with br_imm = 16'h0003 -> next pc = 0x3020. With DELAY_SLOT = 1, IF/ID gets the 0x3014 instruction; with DELAY_SLOT = 0, IF/ID gets NOP and valid = 0.
- Jump and link: j_en = 1, j_index = 26'h0000C40, if_id_pc = 0x3008 -> pc = 0x00003100, if_id_pc8 = 0x3010. Then jr_en = 1, j_en = 1, jr_target = 0x3040 together -> pc = 0x3040 (JR priority).
- Stall: stall = 1 for 3 cycles with br_taken = 1 asserted -> pc, if_id_instr and if_id_pc unchanged every cycle; after release with br_taken still 1, the branch target is taken on that edge.
- Range errors:
  - jr_target = 0x2FFC -> pc_err = 1, pc holds, IF/ID valid = 0.
  - jr_target = 0x3002 -> pc_err = 1.
  - Sequential fetch from 0x3FFC with IM_AW = 10 -> pc_err = 1.
  - Only reset clears pc_err.
- Async reset: assert reset low between clock edges during a stalled JR -> outputs at reset values before the next edge; the JR is not taken after release.
